// File: rtl/nonrestoring_divider.sv
// nonrestoring_divider: sequential unsigned non-restoring divider.
// One shared add/subtract step per RUN cycle, one FIX cycle for the final
// remainder correction, and a one-cycle done pulse with the results.
//
// Optional feature macro: DIVIDER_DIV0_EN (adds div_by_zero and a short
// divide-by-zero path).
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        request, sampled in IDLE or DONE
//   dividend     unsigned dividend, latched on accepted start
//   divisor      unsigned divisor, latched on accepted start
//   busy         high while in RUN or FIX
//   done         one-cycle pulse, results valid in that cycle
//   quotient     result, held until the next accepted start completes
//   remainder    result, held until the next accepted start completes
//   div_by_zero  (DIVIDER_DIV0_EN only) set with done when divisor was 0
module nonrestoring_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIVIDER_DIV0_EN
  ,
  output logic             div_by_zero
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [WIDTH:0]   r, r_n;
  logic [WIDTH-1:0] q, q_n;
  logic [WIDTH-1:0] d, d_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             busy_n, done_n;
  logic [WIDTH-1:0] quotient_n, remainder_n;

  // Shared add/subtract step and final correction.
  logic [WIDTH:0]   rs, step, r_fix;
  logic             sub_mode;

`ifdef DIVIDER_DIV0_EN
  logic zero_div, zero_div_n;
  logic dbz_n;
`endif

  always_comb begin
    sub_mode = ~r[WIDTH];
    rs       = {r[WIDTH-1:0], q[WIDTH-1]};
    step     = sub_mode ? (rs - {1'b0, d}) : (rs + {1'b0, d});
    r_fix    = r[WIDTH] ? (r + {1'b0, d}) : r;
  end

  // Next-state, datapath and output logic.
  always_comb begin
    state_n     = state;
    r_n         = r;
    q_n         = q;
    d_n         = d;
    cnt_n       = cnt;
    quotient_n  = quotient;
    remainder_n = remainder;
`ifdef DIVIDER_DIV0_EN
    zero_div_n  = zero_div;
    dbz_n       = div_by_zero;
`endif

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          q_n     = dividend;
          d_n     = divisor;
          r_n     = '0;
          cnt_n   = CW'(WIDTH);
          state_n = S_RUN;
`ifdef DIVIDER_DIV0_EN
          dbz_n      = 1'b0;
          zero_div_n = (divisor == '0);
          // Skip the iteration; FIX produces the fixed div-by-zero result.
          if (divisor == '0) state_n = S_FIX;
`endif
        end else if (state == S_DONE) begin
          state_n = S_IDLE;
        end
      end
      S_RUN: begin
        r_n   = step;
        q_n   = {q[WIDTH-2:0], ~step[WIDTH]};
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) state_n = S_FIX;
      end
      S_FIX: begin
        r_n         = r_fix;
        quotient_n  = q;
        remainder_n = r_fix[WIDTH-1:0];
`ifdef DIVIDER_DIV0_EN
        if (zero_div) begin
          quotient_n  = '1;
          remainder_n = q;
          dbz_n       = 1'b1;
          zero_div_n  = 1'b0;
        end
`endif
        state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n == S_RUN) || (state_n == S_FIX);
    done_n = (state_n == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      r         <= '0;
      q         <= '0;
      d         <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIVIDER_DIV0_EN
      zero_div    <= 1'b0;
      div_by_zero <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      r         <= r_n;
      q         <= q_n;
      d         <= d_n;
      cnt       <= cnt_n;
      busy      <= busy_n;
      done      <= done_n;
      quotient  <= quotient_n;
      remainder <= remainder_n;
`ifdef DIVIDER_DIV0_EN
      zero_div    <= zero_div_n;
      div_by_zero <= dbz_n;
`endif
    end
  end

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Testbench for nonrestoring_divider: directed vector table, hand-written
// back-to-back / ignored-start / reset-abort sequences, and random operands
// checked against plain integer division.
module tb_nonrestoring_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done;
  logic [W-1:0] quotient, remainder;
`ifdef DIVIDER_DIV0_EN
  logic         div_by_zero;
`endif

  int checks = 0;
  int failures = 0;

  nonrestoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder)
`ifdef DIVIDER_DIV0_EN
    ,
    .div_by_zero(div_by_zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           lat;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Waits up to 20 edges for done; lat = edges until done (-1 on timeout).
  task automatic wait_done(output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  // Full operation from idle; operands are scrambled while busy.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int bcnt,
                       output int qo, output int ro);
    int bc;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = W'($urandom); divisor = W'($urandom);
    bcnt = busy ? 1 : 0;
    wait_done(lat, bc);
    bcnt += bc;
    qo = int'(quotient);
    ro = int'(remainder);
  endtask

  function automatic int exp_lat(input logic [W-1:0] b);
`ifdef DIVIDER_DIV0_EN
    if (b == '0) return 1;
`endif
    return W + 1;
  endfunction

  initial begin
    int lat, bcnt, qo, ro, eq, er;
    logic [W-1:0] a, b;

    vecs[0] = '{a: 4'd13, b: 4'd2, q: 4'd6,  r: 4'd1,  lat: 5};
    vecs[1] = '{a: 4'd7,  b: 4'd9, q: 4'd0,  r: 4'd7,  lat: 5};
    vecs[2] = '{a: 4'd15, b: 4'd1, q: 4'd15, r: 4'd0,  lat: 5};
    vecs[3] = '{a: 4'd0,  b: 4'd8, q: 4'd0,  r: 4'd0,  lat: 5};
`ifdef DIVIDER_DIV0_EN
    vecs[4] = '{a: 4'd13, b: 4'd0, q: 4'd15, r: 4'd13, lat: 1};
`else
    vecs[4] = '{a: 4'd13, b: 4'd0, q: 4'd15, r: 4'd13, lat: 5};
`endif

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_quotient", int'(quotient), 0);
    chk("reset_remainder", int'(remainder), 0);
    rst = 1'b0;

    // Directed vectors
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, lat, bcnt, qo, ro);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_quotient", i), qo, int'(vecs[i].q));
      chk($sformatf("vec%0d_remainder", i), ro, int'(vecs[i].r));
      if (vecs[i].lat == 5) chk($sformatf("vec%0d_busy_cycles", i), bcnt, 5);
`ifdef DIVIDER_DIV0_EN
      chk($sformatf("vec%0d_div_by_zero", i), int'(div_by_zero),
          (vecs[i].b == '0) ? 1 : 0);
`endif
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_pulse", i), int'(done), 0);
      chk($sformatf("vec%0d_hold_quotient", i), int'(quotient), int'(vecs[i].q));
    end

    // Start during busy ignored, then back-to-back start in the done cycle
    @(negedge clk);
    start = 1'b1; dividend = 4'd13; divisor = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; dividend = 4'd2; divisor = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bcnt);
    chk("ignored_start_latency", lat + 3, 5);
    chk("ignored_start_quotient", int'(quotient), 6);
    chk("ignored_start_remainder", int'(remainder), 1);
    start = 1'b1; dividend = 4'd9; divisor = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy_rise", int'(busy), 1);
    wait_done(lat, bcnt);
    chk("b2b_latency", lat, 5);
    chk("b2b_quotient", int'(quotient), 3);
    chk("b2b_remainder", int'(remainder), 0);

    // Reset on the third busy cycle aborts the operation
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b1; dividend = 4'd14; divisor = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    begin
      int seen = 0;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk); #1;
        if (done || busy) seen++;
      end
      chk("abort_no_done", seen, 0);
    end
    do_op(4'd14, 4'd3, lat, bcnt, qo, ro);
    chk("after_abort_latency", lat, 5);
    chk("after_abort_quotient", qo, 4);
    chk("after_abort_remainder", ro, 2);

    // Random operands against integer division
    for (int n = 0; n < 150; n++) begin
      a = W'($urandom);
      b = (n % 10 == 0) ? W'(0) : W'($urandom);
      eq = (b == '0) ? (1 << W) - 1 : int'(a) / int'(b);
      er = (b == '0) ? int'(a) : int'(a) % int'(b);
      do_op(a, b, lat, bcnt, qo, ro);
      chk($sformatf("rand%0d_%0d/%0d_latency", n, a, b), lat, exp_lat(b));
      chk($sformatf("rand%0d_%0d/%0d_quotient", n, a, b), qo, eq);
      chk($sformatf("rand%0d_%0d/%0d_remainder", n, a, b), ro, er);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
